// File: rtl/muldiv_ctrl.sv
// Sequencer for the EX-stage multiplier and divider; owns the HI/LO pair.
// Accepts one md op from EX, stalls the pipeline while it runs, then retires it via DONE.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        ex_stall_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        mul_signed_o,
  output logic [31:0] mul_ina_o,
  output logic [31:0] mul_inb_o,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        stallreq_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned      CNT_W    = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      mul_ina_q, mul_ina_d, mul_inb_q, mul_inb_d;
  logic [31:0]      div_op1_q, div_op1_d, div_op2_q, div_op2_d;
  logic             mul_signed_q, mul_signed_d, div_signed_q, div_signed_d;
  logic             is_mul, is_div;

  assign is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);

  // NOTE: operand holds are reset along with control state because they drive ports
  // that must read 0 out of reset; nothing here is a memory array.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_ina_q    <= '0;
      mul_inb_q    <= '0;
      div_op1_q    <= '0;
      div_op2_q    <= '0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_ina_q    <= mul_ina_d;
      mul_inb_q    <= mul_inb_d;
      div_op1_q    <= div_op1_d;
      div_op2_q    <= div_op2_d;
      mul_signed_q <= mul_signed_d;
      div_signed_q <= div_signed_d;
    end
  end

  // NOTE: every signal gets a hold-value default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_ina_d    = mul_ina_q;
    mul_inb_d    = mul_inb_q;
    div_op1_d    = div_op1_q;
    div_op2_d    = div_op2_q;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid_i) begin
            if (is_mul) begin
              mul_ina_d    = opa_i;
              mul_inb_d    = opb_i;
              mul_signed_d = (op_i == OP_MULT);
              cnt_d        = CNT_INIT;
              state_d      = S_MUL_WAIT;
            end else if (is_div) begin
              div_op1_d    = opa_i;
              div_op2_d    = opb_i;
              div_signed_d = (op_i == OP_DIV);
              // Divide by zero never starts the divider and leaves HI/LO alone.
              state_d      = (opb_i == 32'd0) ? S_DONE : S_DIV_WAIT;
            end else if (op_i == OP_MTHI) begin
              hi_d = opa_i;
            end else if (op_i == OP_MTLO) begin
              lo_d = opa_i;
            end
          end
        end
        S_MUL_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            {hi_d, lo_d} = mul_result_i;
            state_d      = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_DIV_WAIT: begin
          if (div_ready_i) begin
            hi_d    = div_result_i[63:32];
            lo_d    = div_result_i[31:0];
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // op_valid_i still shows the retiring op here; leaving only on !ex_stall_i avoids re-accepting it.
          if (!ex_stall_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o  = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    if (!rst) begin
      if (flush_i) begin
        div_annul_o = (state_q == S_DIV_WAIT);
      end else begin
        case (state_q)
          S_IDLE:     stallreq_o = op_valid_i && (is_mul || is_div);
          S_MUL_WAIT: stallreq_o = 1'b1;
          S_DIV_WAIT: begin
            stallreq_o  = 1'b1;
            div_start_o = !div_ready_i;
          end
          default:    stallreq_o = 1'b0;
        endcase
      end
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign mul_ina_o    = mul_ina_q;
  assign mul_inb_o    = mul_inb_q;
  assign mul_signed_o = mul_signed_q;
  assign div_op1_o    = div_op1_q;
  assign div_op2_o    = div_op2_q;
  assign div_signed_o = div_signed_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scenario tasks with a HI/LO scoreboard queue.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_muldiv_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk, rst, flush, ex_stall, op_valid;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_ina, mul_inb, div_op1, div_op2, hi, lo;
  logic [63:0] mul_result, div_result;
  logic        stallreq, busy;

  logic [63:0] sb_q[$];
  logic [63:0] exp_hilo;
  int          n_cmp = 0;
  int          n_bad = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .ex_stall_i(ex_stall),
    .op_valid_i(op_valid), .op_i(op), .opa_i(opa), .opb_i(opb),
    .mul_signed_o(mul_signed), .mul_ina_o(mul_ina), .mul_inb_o(mul_inb),
    .mul_result_i(mul_result), .div_start_o(div_start), .div_signed_o(div_signed),
    .div_op1_o(div_op1), .div_op2_o(div_op2), .div_annul_o(div_annul),
    .div_ready_i(div_ready), .div_result_i(div_result), .stallreq_o(stallreq),
    .busy_o(busy), .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier environment: product of the registered operands.
  always_comb begin
    if (mul_signed)
      mul_result = {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
    else
      mul_result = {32'h0, mul_ina} * {32'h0, mul_inb};
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; opa = a; opb = b;
  endtask

  task automatic retire();
    op_valid = 1'b0; op = 3'd0; opa = '0; opb = '0;
  endtask

  // Counts stalled cycles of the op just driven; returns in the first unstalled cycle.
  task automatic wait_done(output int stalls, output bit saw_start, output bit timed_out);
    stalls = 0; saw_start = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (div_start) saw_start = 1'b1;
      if (!stallreq) begin
        timed_out = 1'b0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; div_ready = 1'b0; div_result = '0;
    retire();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({stallreq, busy, div_start, div_annul, mul_signed, div_signed} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000",
                        {stallreq, busy, div_start, div_annul, mul_signed, div_signed});
    end
    n_cmp++;
    if ({hi, lo} !== 64'h0) begin
      n_bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo});
    end
    n_cmp++;
    if ({mul_ina, mul_inb, div_op1, div_op2} !== 128'h0) begin
      n_bad++; $display("FAIL reset_operands: got %h want 0", {mul_ina, mul_inb, div_op1, div_op2});
    end
    rst = 1'b0;
    exp_hilo = '0;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    drive_op(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
    exp_hilo[63:32] = 32'hA5A5_A5A5;
    #1;
    n_cmp++;
    if (stallreq !== 1'b0) begin
      n_bad++; $display("FAIL mthi_nostall: got stallreq=%b want 0", stallreq);
    end
    @(negedge clk);
    drive_op(OP_MTLO, 32'h5A5A_5A5A, 32'h0);
    exp_hilo[31:0] = 32'h5A5A_5A5A;
    sb_q.push_back(exp_hilo);
    @(negedge clk);
    retire();
    #1;
    n_cmp++;
    if ({busy, hi, lo} !== {1'b0, sb_q.pop_front()}) begin
      n_bad++; $display("FAIL mthi_mtlo: got busy=%b hilo=%h want busy=0 hilo=%h", busy, {hi, lo}, exp_hilo);
    end
  endtask

  task automatic test_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int stalls; bit saw; bit to;
    logic [63:0] expv;
    if (sgn) expv = 64'(longint'($signed(a)) * longint'($signed(b)));
    else     expv = {32'h0, a} * {32'h0, b};
    @(negedge clk);
    drive_op(sgn ? OP_MULT : OP_MULTU, a, b);
    sb_q.push_back(expv);
    exp_hilo = expv;
    wait_done(stalls, saw, to);
    n_cmp++;
    if (to || stalls != int'(MUL_LAT + 1)) begin
      n_bad++; $display("FAIL mul_stall: got %0d cycles (timeout=%b) want %0d", stalls, to, MUL_LAT + 1);
    end
    n_cmp++;
    if ({busy, mul_signed, mul_ina, mul_inb} !== {1'b1, sgn, a, b}) begin
      n_bad++; $display("FAIL mul_operands: got %b %b %h %h want 1 %b %h %h",
                        busy, mul_signed, mul_ina, mul_inb, sgn, a, b);
    end
    n_cmp++;
    if ({hi, lo} !== sb_q.pop_front()) begin
      n_bad++; $display("FAIL mul_result: got %h want %h", {hi, lo}, expv);
    end
    @(negedge clk);
    retire();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL mul_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_divu();
    int starts = 0;
    logic [63:0] expv;
    expv = {32'(100 % 7), 32'(100 / 7)};
    @(negedge clk);
    drive_op(OP_DIVU, 32'd100, 32'd7);
    sb_q.push_back(expv);
    exp_hilo = expv;
    #1;
    n_cmp++;
    if ({stallreq, div_start} !== 2'b10) begin
      n_bad++; $display("FAIL divu_accept: got stall/start=%b want 10", {stallreq, div_start});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (div_start && stallreq) starts++;
    end
    n_cmp++;
    if (starts != 5 || {div_signed, div_op1, div_op2} !== {1'b0, 32'd100, 32'd7}) begin
      n_bad++; $display("FAIL divu_start: got %0d start cycles ops %b %0d %0d want 5 cycles 0 100 7",
                        starts, div_signed, div_op1, div_op2);
    end
    @(negedge clk);
    div_ready = 1'b1;
    div_result = expv;
    #1;
    n_cmp++;
    if ({stallreq, div_start} !== 2'b10) begin
      n_bad++; $display("FAIL div_start_drop: got stall/start=%b want 10", {stallreq, div_start});
    end
    @(negedge clk);
    div_ready = 1'b0;
    div_result = '0;
    #1;
    n_cmp++;
    if ({stallreq, hi, lo} !== {1'b0, sb_q.pop_front()}) begin
      n_bad++; $display("FAIL divu_result: got stall=%b hilo=%h want 0 %h", stallreq, {hi, lo}, expv);
    end
    @(negedge clk);
    retire();
  endtask

  task automatic test_div_zero();
    int stalls; bit saw; bit to;
    @(negedge clk);
    drive_op(OP_DIV, 32'd7, 32'd0);
    sb_q.push_back(exp_hilo);
    wait_done(stalls, saw, to);
    n_cmp++;
    if (to || stalls != 1 || saw) begin
      n_bad++; $display("FAIL div_zero_stall: got %0d cycles start_seen=%b timeout=%b want 1 0 0", stalls, saw, to);
    end
    n_cmp++;
    if ({busy, hi, lo} !== {1'b1, sb_q.pop_front()}) begin
      n_bad++; $display("FAIL div_zero_hilo: got busy=%b hilo=%h want 1 %h", busy, {hi, lo}, exp_hilo);
    end
    @(negedge clk);
    retire();
  endtask

  task automatic test_flush_div();
    @(negedge clk);
    drive_op(OP_DIV, -32'sd20, 32'd3);
    sb_q.push_back(exp_hilo);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({div_signed, div_start, stallreq} !== 3'b111) begin
      n_bad++; $display("FAIL div_wait: got signed/start/stall=%b want 111", {div_signed, div_start, stallreq});
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({div_annul, stallreq, div_start} !== 3'b100) begin
      n_bad++; $display("FAIL flush_annul: got annul/stall/start=%b want 100", {div_annul, stallreq, div_start});
    end
    @(negedge clk);
    flush = 1'b0;
    retire();
    #1;
    n_cmp++;
    if ({div_annul, busy, hi, lo} !== {2'b00, sb_q.pop_front()}) begin
      n_bad++; $display("FAIL flush_idle: got annul=%b busy=%b hilo=%h want 0 0 %h", div_annul, busy, {hi, lo}, exp_hilo);
    end
  endtask

  task automatic test_done_hold();
    int stalls; bit saw; bit to;
    int held = 0;
    @(negedge clk);
    drive_op(OP_MULT, 32'd7, 32'd6);
    exp_hilo = 64'd42;
    sb_q.push_back(exp_hilo);
    wait_done(stalls, saw, to);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (!stallreq && busy) held++;
    end
    n_cmp++;
    if (to || held != 3) begin
      n_bad++; $display("FAIL done_hold: got %0d held cycles (timeout=%b) want 3", held, to);
    end
    ex_stall = 1'b0;
    @(negedge clk);
    retire();
    #1;
    n_cmp++;
    if ({busy, stallreq, hi, lo} !== {2'b00, sb_q.pop_front()}) begin
      n_bad++; $display("FAIL done_release: got busy=%b stall=%b hilo=%h want 0 0 %h", busy, stallreq, {hi, lo}, exp_hilo);
    end
  endtask

  task automatic test_back_to_back();
    int stalls; bit saw; bit to;
    @(negedge clk);
    drive_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    exp_hilo = 64'h1_0000_0000;
    wait_done(stalls, saw, to);
    @(negedge clk);
    drive_op(OP_MTLO, 32'h0000_CAFE, 32'h0);
    exp_hilo[31:0] = 32'h0000_CAFE;
    sb_q.push_back(exp_hilo);
    #1;
    n_cmp++;
    if (to || {stallreq, busy} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_mtlo: got stall/busy=%b timeout=%b want 00 0", {stallreq, busy}, to);
    end
    @(negedge clk);
    retire();
    #1;
    n_cmp++;
    if ({hi, lo} !== sb_q.pop_front()) begin
      n_bad++; $display("FAIL b2b_hilo: got %h want %h", {hi, lo}, exp_hilo);
    end
  endtask

  task automatic test_rst_mul();
    @(negedge clk);
    drive_op(OP_MULT, 32'd9, 32'd9);
    @(negedge clk);
    rst = 1'b1;
    retire();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    exp_hilo = '0;
    #1;
    n_cmp++;
    if ({busy, hi, lo} !== 65'h0) begin
      n_bad++; $display("FAIL rst_mul: got busy=%b hilo=%h want 0 0", busy, {hi, lo});
    end
    drive_op(OP_MTHI, 32'h0000_1234, 32'h0);
    exp_hilo[63:32] = 32'h0000_1234;
    sb_q.push_back(exp_hilo);
    #1;
    n_cmp++;
    if (stallreq !== 1'b0) begin
      n_bad++; $display("FAIL rst_mthi_stall: got %b want 0", stallreq);
    end
    @(negedge clk);
    retire();
    #1;
    n_cmp++;
    if ({hi, lo} !== sb_q.pop_front()) begin
      n_bad++; $display("FAIL rst_mthi: got %h want %h", {hi, lo}, exp_hilo);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mul(1'b1, -32'sd3, 32'd5);
    test_mul(1'b0, 32'hFFFF_FFFF, 32'd2);
    test_divu();
    test_div_zero();
    test_flush_div();
    test_done_hold();
    test_back_to_back();
    test_rst_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
